// File: rtl/uart_tx_shift.sv
// uart_tx_shift: parallel-in/serial-out UART transmitter (start, 8 data bits LSB first, optional parity, stop).
// Latency: start bit appears on tx the cycle after an accepted ld; a frame lasts 10*BAUD_DIV (11*BAUD_DIV with parity) clocks.
// Backpressure: tx_rdy=0 while a frame is in flight; ld is ignored then (no queueing), so the producer must pace on tx_rdy.
module uart_tx_shift #(
  parameter int BAUD_DIV   = 5208,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic       ld,
  output logic       tx,
  output logic       tx_rdy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  // Last clock of the current bit period.
  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state, bit timing and next tx value; tx is computed one cycle ahead so it can be registered.
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (ld) begin
          state_d = S_START;
          shreg_d = d;
          // Parity is fixed at capture time so later changes on d cannot leak into the frame.
          par_d   = (^d) ^ PARITY_ODD;
          bit_d   = 3'd0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset forces the line idle-high mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx     = tx_q;
  assign tx_rdy = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_shift.sv
// tb_uart_tx_shift: drives three transmitters (no parity, even, odd) from shared inputs.
// Latency: frames start the cycle after an accepted ld; checks sample on the falling edge.
// Backpressure: ld is driven regardless of tx_rdy; ignored loads must leave frames untouched.
module tb_uart_tx_shift;

  localparam int B = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d     = 8'd0;
  logic       ld    = 1'b0;
  logic [2:0] tx_w;
  logic [2:0] rdy_w;

  int checks = 0;
  int errors = 0;

  // Frame-level reference state per instance.
  bit          m_busy [3] = '{default: 1'b0};
  int          m_t    [3] = '{default: 0};
  logic [10:0] m_fr   [3] = '{default: '1};
  logic        m_et, m_er;

  always #5 clk = ~clk;

  uart_tx_shift #(.BAUD_DIV(B), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .d(d), .ld(ld), .tx(tx_w[0]), .tx_rdy(rdy_w[0]));
  uart_tx_shift #(.BAUD_DIV(B), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .d(d), .ld(ld), .tx(tx_w[1]), .tx_rdy(rdy_w[1]));
  uart_tx_shift #(.BAUD_DIV(B), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .d(d), .ld(ld), .tx(tx_w[2]), .tx_rdy(rdy_w[2]));

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbits(input int i);
    return (i == 0) ? 10 : 11;
  endfunction

  // Frame bits in time order: start, d[0..7], [parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] dv, input int i);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int j = 0; j < 8; j++) f[j+1] = dv[j];
    if (i != 0) f[9] = (i == 2) ? ~(^dv) : (^dv);
    return f;
  endfunction

  // Reference: an idle transmitter accepts ld and then plays its frame for nbits*B cycles.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_busy[i] <= 1'b0;
        m_t[i]    <= 0;
      end else if (m_busy[i]) begin
        m_t[i] <= m_t[i] + 1;
        if (m_t[i] + 1 == nbits(i) * B) m_busy[i] <= 1'b0;
      end else if (ld) begin
        m_fr[i]   <= frame_of(d, i);
        m_t[i]    <= 0;
        m_busy[i] <= 1'b1;
      end
    end
  end

  // Every cycle: DUT outputs against the reference.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_er = ~m_busy[i];
      m_et = m_busy[i] ? m_fr[i][m_t[i] / B] : 1'b1;
      chk($sformatf("model tx inst%0d", i), tx_w[i], m_et);
      chk($sformatf("model tx_rdy inst%0d", i), rdy_w[i], m_er);
    end
  end

  // Literal frame check, started on the falling edge right after the accepting edge (k=0).
  // Expected vectors are written in time order, left to right.
  task automatic check_frames(input logic [0:10] e0, input logic [0:10] e1,
                              input logic [0:10] e2, input int inject);
    logic [0:10] e [3];
    int n;
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    for (int k = 0; k <= 44; k++) begin
      for (int i = 0; i < 3; i++) begin
        n = nbits(i) * B;
        if (k < n) begin
          if (k % B == 1)
            chk($sformatf("frame inst%0d bit%0d", i, k / B), tx_w[i], e[i][k / B]);
          chk($sformatf("rdy low inst%0d k%0d", i, k), rdy_w[i], 1'b0);
        end else if (k == n) begin
          chk($sformatf("rdy rise inst%0d", i), rdy_w[i], 1'b1);
          chk($sformatf("idle tx inst%0d", i), tx_w[i], 1'b1);
        end
      end
      if (k == inject) begin
        ld = 1'b1;
        d  = 8'hFF;
      end else begin
        ld = 1'b0;
        d  = 8'($urandom);
      end
      if (k < 44) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles, then idle with ld low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("reset tx inst%0d", i), tx_w[i], 1'b1);
        chk($sformatf("reset rdy inst%0d", i), rdy_w[i], 1'b1);
      end
      @(negedge clk);
    end

    // 0xA5 with an ignored load of 0xFF part-way through, and d scrambled mid-frame.
    d  = 8'hA5;
    ld = 1'b1;
    @(negedge clk);
    check_frames(11'b0_10100101_1_0, 11'b0_10100101_0_1, 11'b0_10100101_1_1, 13);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk($sformatf("no 2nd frame inst%0d", i), rdy_w[i], 1'b1);
    end

    // 0x07: odd count of ones, so even parity = 1, odd parity = 0.
    @(negedge clk);
    d  = 8'h07;
    ld = 1'b1;
    @(negedge clk);
    check_frames(11'b0_11100000_1_0, 11'b0_11100000_1_1, 11'b0_11100000_0_1, -1);

    // Asynchronous reset in the middle of data bit 4.
    @(negedge clk);
    d  = 8'hC3;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    repeat (20) @(negedge clk);
    chk("busy before reset", rdy_w[0], 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async reset tx inst%0d", i), tx_w[i], 1'b1);
      chk($sformatf("async reset rdy inst%0d", i), rdy_w[i], 1'b1);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    d  = 8'h00;
    ld = 1'b1;
    @(negedge clk);
    check_frames(11'b0_00000000_1_0, 11'b0_00000000_0_1, 11'b0_00000000_1_1, -1);

    // ld held high with 0x55: two back-to-back frames on inst0, stop stretched to B+1.
    @(negedge clk);
    d  = 8'h55;
    ld = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 81; k++) begin
      logic [0:10] e;
      int r;
      e = 11'b0_10101010_1_0;
      r = k % 41;
      if (r < 40 && r % B == 1)
        chk($sformatf("b2b frame%0d bit%0d", k / 41, r / B), tx_w[0], e[r / B]);
      if (r >= 36) chk($sformatf("b2b stop k%0d", k), tx_w[0], 1'b1);
      if (k == 41) chk("b2b second start", tx_w[0], 1'b0);
      chk($sformatf("b2b rdy k%0d", k), rdy_w[0], (r == 40) ? 1'b1 : 1'b0);
      if (k == 81) ld = 1'b0;
      else @(negedge clk);
    end
    repeat (60) @(negedge clk);

    // Random loads, data and occasional resets, checked by the reference every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ld = ($urandom_range(0, 2) == 0);
      d  = 8'($urandom);
      reset = 1'b0;
      if ($urandom_range(0, 299) == 0) #2 reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    ld    = 1'b0;
    repeat (50) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
